// File: rtl/count_wrap_monitor.sv
// Observer for a 4-bit up counter: wrap/match/jump pulses, saturating wrap total, match-counting FSM.
// Optional non-sequential step detection is enabled by defining COUNT_JUMP_DETECT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | disarmed, Hits held at 0, no Match pulses
// ST_ARMED | counting target matches into Hits
// ST_DONE  | MATCH_LIMIT matches seen, Hits frozen, Done asserted

module count_wrap_monitor #(
    parameter int WRAP_W      = 8,
    parameter int MATCH_LIMIT = 3
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [3:0]        Count,
    input  logic [3:0]        Target,
    input  logic              TargetLoad,
    input  logic              Arm,
    output logic              Carry,
    output logic              Match,
    output logic              Jump,
    output logic [WRAP_W-1:0] WrapCount,
    output logic              Ovf,
    output logic [3:0]        Hits,
    output logic              Done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(MATCH_LIMIT);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] prev_q;
    logic       prev_vld;
    logic [3:0] target_q;
    logic [3:0] hits_d;
    logic [3:0] hits_inc;
    logic       carry_d;
    logic       match_hit;
    logic       match_d;
    logic       wrap_sat;

    assign hits_inc = Hits + 4'd1;
    assign wrap_sat = &WrapCount;
    assign Done     = (state_q == ST_DONE);

    // Nothing is evaluated until a first sample exists after Clear.
    assign carry_d   = prev_vld && (prev_q == 4'hF) && (Count == 4'h0);
    assign match_hit = prev_vld && (state_q == ST_ARMED) && Arm &&
                       (Count == target_q) && (prev_q != target_q);

    always_comb begin
        state_d = state_q;
        hits_d  = Hits;
        match_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Arm) begin
                    state_d = ST_ARMED;
                    hits_d  = 4'd0;
                end
            end
            ST_ARMED: begin
                if (!Arm) begin
                    state_d = ST_IDLE;
                    hits_d  = 4'd0;
                end else if (match_hit) begin
                    match_d = 1'b1;
                    // A target reload starts a fresh episode, so the match does not count.
                    if (TargetLoad) begin
                        hits_d = 4'd0;
                    end else begin
                        hits_d = hits_inc;
                        if (hits_inc == LIMIT) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (TargetLoad) begin
                    hits_d = 4'd0;
                end
            end
            ST_DONE: begin
                if (!Arm) begin
                    state_d = ST_IDLE;
                    hits_d  = 4'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hits_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            state_q   <= ST_IDLE;
            prev_q    <= 4'h0;
            prev_vld  <= 1'b0;
            target_q  <= 4'h0;
            Hits      <= 4'd0;
            Carry     <= 1'b0;
            Match     <= 1'b0;
            WrapCount <= '0;
            Ovf       <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= Count;
            prev_vld <= 1'b1;
            Hits     <= hits_d;
            Carry    <= carry_d;
            Match    <= match_d;
            if (TargetLoad) begin
                target_q <= Target;
            end
            if (carry_d) begin
                if (wrap_sat) begin
                    Ovf <= 1'b1;
                end else begin
                    WrapCount <= WrapCount + 1'b1;
                end
            end
        end
    end

`ifdef COUNT_JUMP_DETECT_EN
    logic seq_step;
    logic hold_step;
    logic jump_d;

    // A wrap F->0 is a sequential step because the increment is modulo 16.
    assign seq_step  = (Count == (prev_q + 4'd1));
    assign hold_step = (Count == prev_q);
    assign jump_d    = prev_vld && !seq_step && !hold_step;

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            Jump <= 1'b0;
        end else begin
            Jump <= jump_d;
        end
    end
`else
    assign Jump = 1'b0;
`endif

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: directed steps plus randomized traffic against an arithmetic reference model.
// Jump expectations follow COUNT_JUMP_DETECT_EN when the bench is built with the same define.

module tb_count_wrap_monitor;

`ifdef COUNT_JUMP_DETECT_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] Count = 4'h0;
    logic [3:0] Target = 4'h0;
    logic       TargetLoad = 1'b0;
    logic       Arm = 1'b0;

    logic       Carry, Match, Jump, Ovf, Done;
    logic [7:0] WrapCount;
    logic [3:0] Hits;
    logic       Carry2, Match2, Jump2, Ovf2, Done2;
    logic [1:0] WrapCount2;
    logic [3:0] Hits2;

    count_wrap_monitor #(.WRAP_W(8), .MATCH_LIMIT(3)) dut (
        .Clock(Clock), .Clear(Clear), .Count(Count), .Target(Target),
        .TargetLoad(TargetLoad), .Arm(Arm),
        .Carry(Carry), .Match(Match), .Jump(Jump), .WrapCount(WrapCount),
        .Ovf(Ovf), .Hits(Hits), .Done(Done)
    );

    count_wrap_monitor #(.WRAP_W(2), .MATCH_LIMIT(3)) dut2 (
        .Clock(Clock), .Clear(Clear), .Count(Count), .Target(Target),
        .TargetLoad(TargetLoad), .Arm(Arm),
        .Carry(Carry2), .Match(Match2), .Jump(Jump2), .WrapCount(WrapCount2),
        .Ovf(Ovf2), .Hits(Hits2), .Done(Done2)
    );

    always #5 Clock = ~Clock;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model: episode as a small integer, wraps as saturating integers.
    localparam int M_IDLE = 0, M_ARMED = 1, M_DONE = 2;
    int m_prev, m_target, m_state, m_hits, m_w8, m_w2;
    bit m_vld, m_o8, m_o2, e_carry, e_match, e_jump;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit ev, seq, hold, hit;
        if (!Clear) begin
            m_prev = 0; m_vld = 0; m_target = 0; m_state = M_IDLE; m_hits = 0;
            m_w8 = 0; m_w2 = 0; m_o8 = 0; m_o2 = 0;
            e_carry = 0; e_match = 0; e_jump = 0;
            return;
        end
        ev      = m_vld;
        seq     = (((m_prev + 1) % 16) == int'(Count));
        hold    = (m_prev == int'(Count));
        e_carry = ev && m_prev == 15 && Count == 0;
        e_jump  = JEN && ev && !seq && !hold;
        hit     = ev && Arm && m_state == M_ARMED && int'(Count) == m_target && m_prev != m_target;
        e_match = hit;
        if (e_carry) begin
            if (m_w8 == 255) m_o8 = 1; else m_w8++;
            if (m_w2 == 3) m_o2 = 1; else m_w2++;
        end
        if (!Arm) begin
            m_state = M_IDLE; m_hits = 0;
        end else if (m_state == M_IDLE) begin
            m_state = M_ARMED; m_hits = 0;
        end else if (m_state == M_ARMED) begin
            if (TargetLoad) m_hits = 0;
            else if (hit) begin
                m_hits++;
                if (m_hits == 3) m_state = M_DONE;
            end
        end
        if (TargetLoad) m_target = int'(Target);
        m_prev = int'(Count);
        m_vld  = 1;
    endtask

    task automatic cyc(input logic [3:0] c, input logic a, input logic tl = 1'b0,
                       input logic [3:0] tg = 4'h0, input logic clr = 1'b1);
        @(negedge Clock);
        Count = c; Arm = a; TargetLoad = tl; Target = tg; Clear = clr;
        @(posedge Clock);
        model_edge();
        #1;
        chk("carry", 32'(Carry), 32'(e_carry));
        chk("match", 32'(Match), 32'(e_match));
        chk("jump", 32'(Jump), 32'(e_jump));
        chk("wrapcount", 32'(WrapCount), 32'(m_w8));
        chk("ovf", 32'(Ovf), 32'(m_o8));
        chk("hits", 32'(Hits), 32'(m_hits));
        chk("done", 32'(Done), 32'(m_state == M_DONE));
        chk("wrapcount_w2", 32'(WrapCount2), 32'(m_w2));
        chk("ovf_w2", 32'(Ovf2), 32'(m_o2));
    endtask

    task automatic run_lap(input logic a);
        for (int v = 1; v < 16; v++) cyc(4'(v), a);
        cyc(4'h0, a);
    endtask

    initial begin
        logic [3:0] c;
        logic       a, tl, clr;
        logic [1:0] exp_w2 [4];
        exp_w2[0] = 2'd1; exp_w2[1] = 2'd2; exp_w2[2] = 2'd3; exp_w2[3] = 2'd3;

        // 1: reset, then one full lap
        cyc(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("reset_wrap", 32'(WrapCount), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        cyc(4'h0, 1'b0);
        run_lap(1'b0);
        chk("t1_carry", 32'(Carry), 32'd1);
        chk("t1_wrap", 32'(WrapCount), 32'd1);

        // 2: saturation on the 2-bit instance
        cyc(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(4'h0, 1'b0);
        for (int l = 0; l < 4; l++) begin
            run_lap(1'b0);
            chk("t2_wrap_w2", 32'(WrapCount2), 32'(exp_w2[l]));
        end
        chk("t2_ovf_w2", 32'(Ovf2), 32'd1);
        cyc(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        chk("t2_clr_wrap", 32'(WrapCount2), 32'd0);
        chk("t2_clr_ovf", 32'(Ovf2), 32'd0);

        // 3: target 5, three laps, parked on 5 in lap 1
        cyc(4'h0, 1'b0, 1'b1, 4'h5);
        cyc(4'h0, 1'b1);
        for (int v = 1; v < 16; v++) begin
            cyc(4'(v), 1'b1);
            if (v == 5) for (int k = 0; k < 3; k++) cyc(4'h5, 1'b1);
        end
        cyc(4'h0, 1'b1);
        chk("t3_hits1", 32'(Hits), 32'd1);
        run_lap(1'b1);
        chk("t3_hits2", 32'(Hits), 32'd2);
        run_lap(1'b1);
        chk("t3_hits3", 32'(Hits), 32'd3);
        chk("t3_done", 32'(Done), 32'd1);
        cyc(4'h1, 1'b0);
        chk("t3_idle_hits", 32'(Hits), 32'd0);

        // 4: target 0, carry and match together; then Arm drop wins
        cyc(4'hE, 1'b1, 1'b1, 4'h0);
        cyc(4'hF, 1'b1);
        cyc(4'h0, 1'b1);
        chk("t4_carry", 32'(Carry), 32'd1);
        chk("t4_match", 32'(Match), 32'd1);
        cyc(4'hE, 1'b1);
        cyc(4'hF, 1'b1);
        cyc(4'h0, 1'b0);
        chk("t4_armdrop_match", 32'(Match), 32'd0);

        // 5: loads and clears of the watched counter
        cyc(4'h3, 1'b0);
        cyc(4'h9, 1'b0);
        chk("t5_jump1", 32'(Jump), 32'(JEN));
        cyc(4'h0, 1'b0);
        chk("t5_jump2", 32'(Jump), 32'(JEN));

        // 6: Clear while DONE with seven wraps accumulated
        cyc(4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        cyc(4'h0, 1'b0, 1'b1, 4'h5);
        cyc(4'h0, 1'b1);
        for (int l = 0; l < 7; l++) run_lap(1'b1);
        chk("t6_pre_wrap", 32'(WrapCount), 32'd7);
        chk("t6_pre_done", 32'(Done), 32'd1);
        cyc(4'h5, 1'b1, 1'b0, 4'h0, 1'b0);
        chk("t6_clr_wrap", 32'(WrapCount), 32'd0);
        chk("t6_clr_done", 32'(Done), 32'd0);
        cyc(4'h0, 1'b1);
        chk("t6_first_match", 32'(Match), 32'd0);
        cyc(4'h0, 1'b1);

        // randomized traffic: mostly counting, occasional loads, holds, re-arms, clears
        c = 4'h0; a = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       c = 4'($urandom_range(0, 15));
                1:       c = c;
                default: c = c + 4'd1;
            endcase
            if ($urandom_range(0, 39) == 0) a = ~a;
            tl  = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 199) != 0);
            cyc(c, a, tl, 4'($urandom_range(0, 15)), clr);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
